mem_access_unit: RTL and testbench

Load/store requester for `data_memory`, the pipeline-MEM-stage side of the memory interface. It accepts one load or store per handshake and drives `data_memory`'s `write`/`address`/`write_data` port. It consumes `read_data`, which is combinational and word-addressed by byte address. It also adds byte and halfword access: sign or zero extension on loads, and read-modify-write on sub-word stores, because the memory only writes whole words.

---
 rtl/mem_access_pkg.sv | 32 +++
 rtl/mem_lane_align.sv | 46 ++++
 rtl/mem_access_unit.sv | 150 +++++++++++++++
 tb/tb_mem_access_unit.sv | 337 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_access_pkg.sv
// Purpose: shared size encodings, FSM state type and alignment check for mem_access_unit.
// Latency: n/a (types and a pure function only).
// Backpressure: n/a.
package mem_access_pkg;

  localparam logic [1:0] SIZE_BYTE = 2'b00;
  localparam logic [1:0] SIZE_HALF = 2'b01;
  localparam logic [1:0] SIZE_WORD = 2'b10;
  localparam logic [1:0] SIZE_ILL  = 2'b11;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_RD     = 3'd1,
    ST_RMW_RD = 3'd2,
    ST_WR     = 3'd3,
    ST_RMW_WR = 3'd4,
    ST_RESP   = 3'd5
  } state_e;

  // Natural alignment per access size; the illegal size is always rejected.
  function automatic logic is_misaligned(input logic [1:0] size, input logic [1:0] lane);
    logic mis;
    case (size)
      SIZE_BYTE: mis = 1'b0;
      SIZE_HALF: mis = lane[0];
      SIZE_WORD: mis = (lane != 2'b00);
      default:   mis = 1'b1;
    endcase
    return mis;
  endfunction

endpackage

// File: rtl/mem_lane_align.sv
// Purpose: byte/half lane extraction with sign/zero extension, and sub-word store merge.
// Latency: combinational.
// Backpressure: none.
// Ports: word_i (memory word), lane_i (addr[1:0]), size_i, unsigned_i, wdata_i (right-justified
//        store data) -> load_o (extended load value), merge_o (word with store lane replaced).
module mem_lane_align
  import mem_access_pkg::*;
(
  input  logic [31:0] word_i,
  input  logic [1:0]  lane_i,
  input  logic [1:0]  size_i,
  input  logic        unsigned_i,
  input  logic [31:0] wdata_i,
  output logic [31:0] load_o,
  output logic [31:0] merge_o
);

  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  always_comb begin
    byte_sel = word_i[{lane_i, 3'b000} +: 8];
    half_sel = word_i[{lane_i[1], 4'b0000} +: 16];
    load_o   = '0;
    merge_o  = word_i;
    case (size_i)
      SIZE_BYTE: begin
        load_o = {{24{~unsigned_i & byte_sel[7]}}, byte_sel};
        merge_o[{lane_i, 3'b000} +: 8] = wdata_i[7:0];
      end
      SIZE_HALF: begin
        load_o = {{16{~unsigned_i & half_sel[15]}}, half_sel};
        merge_o[{lane_i[1], 4'b0000} +: 16] = wdata_i[15:0];
      end
      SIZE_WORD: begin
        load_o  = word_i;
        merge_o = wdata_i;
      end
      default: begin
        load_o  = '0;
        merge_o = word_i;
      end
    endcase
  end

endmodule

// File: rtl/mem_access_unit.sv
// Purpose: MEM-stage load/store requester for a word-only data_memory, adding byte/half access.
// Latency: accept-to-response 2 edges (load, word store), 3 (sub-word store), 1 (misaligned).
// Backpressure: req_ready only in IDLE; resp_valid is a one-cycle pulse with no backpressure.
// Ports: req_* request handshake and fields; resp_* completion pulse, load data, misaligned flag;
//        mem_* drive data_memory (word-aligned address, write strobe, write data, comb read data).
module mem_access_unit
  import mem_access_pkg::*;
#(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic                  req_write,
  input  logic [1:0]            req_size,
  input  logic                  req_unsigned,
  input  logic [ADDR_WIDTH-1:0] req_addr,
  input  logic [DATA_WIDTH-1:0] req_wdata,
  output logic                  resp_valid,
  output logic [DATA_WIDTH-1:0] resp_rdata,
  output logic                  resp_misaligned,
  output logic                  mem_write,
  output logic [ADDR_WIDTH-1:0] mem_address,
  output logic [DATA_WIDTH-1:0] mem_write_data,
  input  logic [DATA_WIDTH-1:0] mem_read_data
);

  state_e                  state_q, state_d;
  logic                    write_q, write_d;
  logic                    unsigned_q, unsigned_d;
  logic [1:0]              size_q, size_d;
  logic [ADDR_WIDTH-1:0]   addr_q, addr_d;
  logic [DATA_WIDTH-1:0]   wdata_q, wdata_d;
  logic [DATA_WIDTH-1:0]   rdata_q, rdata_d;
  logic [DATA_WIDTH-1:0]   merge_q, merge_d;
  logic                    mis_q, mis_d;

  logic [DATA_WIDTH-1:0]   load_val;
  logic [DATA_WIDTH-1:0]   merge_val;
  logic [ADDR_WIDTH-1:0]   word_addr;

  // Lane logic works on the latched request so memory-side outputs never see req_* directly.
  mem_lane_align u_align (
    .word_i     (mem_read_data),
    .lane_i     (addr_q[1:0]),
    .size_i     (size_q),
    .unsigned_i (unsigned_q),
    .wdata_i    (wdata_q),
    .load_o     (load_val),
    .merge_o    (merge_val)
  );

  assign word_addr = {addr_q[ADDR_WIDTH-1:2], 2'b00};

  always_comb begin
    state_d    = state_q;
    write_d    = write_q;
    unsigned_d = unsigned_q;
    size_d     = size_q;
    addr_d     = addr_q;
    wdata_d    = wdata_q;
    rdata_d    = rdata_q;
    merge_d    = merge_q;
    mis_d      = mis_q;

    req_ready       = 1'b0;
    resp_valid      = 1'b0;
    resp_rdata      = '0;
    resp_misaligned = 1'b0;
    mem_write       = 1'b0;
    mem_address     = '0;
    mem_write_data  = '0;

    case (state_q)
      ST_IDLE: begin
        req_ready = 1'b1;
        if (req_valid) begin
          write_d    = req_write;
          unsigned_d = req_unsigned;
          size_d     = req_size;
          addr_d     = req_addr;
          wdata_d    = req_wdata;
          // Cleared here so stores and rejected requests respond with zero data.
          rdata_d    = '0;
          mis_d      = is_misaligned(req_size, req_addr[1:0]);
          if (mis_d)                  state_d = ST_RESP;
          else if (!req_write)        state_d = ST_RD;
          else if (req_size == SIZE_WORD) state_d = ST_WR;
          else                        state_d = ST_RMW_RD;
        end
      end
      ST_RD: begin
        mem_address = word_addr;
        rdata_d     = load_val;
        state_d     = ST_RESP;
      end
      ST_RMW_RD: begin
        mem_address = word_addr;
        merge_d     = merge_val;
        state_d     = ST_RMW_WR;
      end
      ST_WR: begin
        mem_write      = 1'b1;
        mem_address    = word_addr;
        mem_write_data = wdata_q;
        state_d        = ST_RESP;
      end
      ST_RMW_WR: begin
        mem_write      = 1'b1;
        mem_address    = word_addr;
        mem_write_data = merge_q;
        state_d        = ST_RESP;
      end
      ST_RESP: begin
        resp_valid      = 1'b1;
        resp_rdata      = rdata_q;
        resp_misaligned = mis_q;
        state_d         = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ST_IDLE;
      write_q    <= 1'b0;
      unsigned_q <= 1'b0;
      size_q     <= SIZE_BYTE;
      addr_q     <= '0;
      wdata_q    <= '0;
      rdata_q    <= '0;
      merge_q    <= '0;
      mis_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      write_q    <= write_d;
      unsigned_q <= unsigned_d;
      size_q     <= size_d;
      addr_q     <= addr_d;
      wdata_q    <= wdata_d;
      rdata_q    <= rdata_d;
      merge_q    <= merge_d;
      mis_q      <= mis_d;
    end
  end

endmodule

// File: tb/tb_mem_access_unit.sv
// Purpose: self-checking bench for mem_access_unit against a word-array memory and a byte-lane reference model.
// Latency: n/a.
// Backpressure: n/a.
module tb_mem_access_unit;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic        req_write = 1'b0;
  logic [1:0]  req_size = 2'b00;
  logic        req_unsigned = 1'b0;
  logic [31:0] req_addr = '0;
  logic [31:0] req_wdata = '0;
  logic        resp_valid;
  logic [31:0] resp_rdata;
  logic        resp_misaligned;
  logic        mem_write;
  logic [31:0] mem_address;
  logic [31:0] mem_write_data;
  logic [31:0] mem_read_data;

  int n_run  = 0;
  int n_fail = 0;

  logic [31:0] mem     [0:63];
  logic [31:0] ref_mem [0:63];

  always #5 clk = ~clk;

  mem_access_unit #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .req_valid       (req_valid),
    .req_ready       (req_ready),
    .req_write       (req_write),
    .req_size        (req_size),
    .req_unsigned    (req_unsigned),
    .req_addr        (req_addr),
    .req_wdata       (req_wdata),
    .resp_valid      (resp_valid),
    .resp_rdata      (resp_rdata),
    .resp_misaligned (resp_misaligned),
    .mem_write       (mem_write),
    .mem_address     (mem_address),
    .mem_write_data  (mem_write_data),
    .mem_read_data   (mem_read_data)
  );

  // data_memory stand-in: combinational word read, write committed on the rising edge.
  assign mem_read_data = mem[mem_address[7:2]];
  always @(posedge clk) if (mem_write) mem[mem_address[7:2]] <= mem_write_data;

  // ---------------- reference model (byte-lane arithmetic) ----------------
  function automatic bit ref_mis(input int sz, input int a);
    return (sz == 3) || (sz == 1 && (a % 2) != 0) || (sz == 2 && (a % 4) != 0);
  endfunction

  function automatic logic [31:0] ref_load(input logic [31:0] w, input int a, input int sz, input bit u);
    logic [31:0] v;
    if (sz == 0) begin
      v = (w >> (8 * (a % 4))) & 32'hFF;
      if (!u && v >= 32'd128) v = v | 32'hFFFFFF00;
    end else if (sz == 1) begin
      v = (w >> (16 * ((a / 2) % 2))) & 32'hFFFF;
      if (!u && v >= 32'd32768) v = v | 32'hFFFF0000;
    end else begin
      v = w;
    end
    return v;
  endfunction

  function automatic logic [31:0] ref_store(input logic [31:0] w, input int a, input int sz, input logic [31:0] d);
    logic [31:0] mask;
    int sh;
    if (sz == 2) return d;
    mask = (sz == 0) ? 32'hFF : 32'hFFFF;
    sh   = (sz == 0) ? 8 * (a % 4) : 16 * ((a / 2) % 2);
    return (w & ~(mask << sh)) | ((d & mask) << sh);
  endfunction

  function automatic int ref_lat(input bit w, input int sz, input int a);
    if (ref_mis(sz, a)) return 1;
    if (w && sz != 2) return 3;
    return 2;
  endfunction

  // ---------------- single-request driver ----------------
  logic [31:0] r_rdata, r_waddr, r_wdata;
  logic        r_mis;
  int          r_lat, r_nwr;
  bit          r_rdy_bad, r_tmo;

  task automatic issue(input bit w, input int sz, input bit u, input int a, input logic [31:0] d);
    int guard;
    r_lat = 0; r_nwr = 0; r_rdy_bad = 0; r_tmo = 0;
    r_rdata = 'x; r_mis = 1'bx; r_waddr = '0; r_wdata = '0;
    @(negedge clk);
    req_write = w; req_size = 2'(sz); req_unsigned = u; req_addr = a; req_wdata = d;
    req_valid = 1'b1;
    guard = 0;
    while (!req_ready && guard < 20) begin @(negedge clk); guard++; end
    if (!req_ready) begin r_tmo = 1; req_valid = 1'b0; return; end
    @(posedge clk); #1 req_valid = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      r_lat++;
      if (req_ready) r_rdy_bad = 1;
      if (mem_write) begin r_nwr++; r_waddr = mem_address; r_wdata = mem_write_data; end
      if (resp_valid) begin r_rdata = resp_rdata; r_mis = resp_misaligned; return; end
    end
    r_tmo = 1;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    rst_n = 1'b1;
    #1 rst_n = 1'b0;
    #2;
    n_run++;
    if ({req_ready, resp_valid, resp_misaligned, mem_write} !== 4'b1000 ||
        resp_rdata !== 32'd0 || mem_address !== 32'd0 || mem_write_data !== 32'd0) begin
      n_fail++;
      $display("FAIL reset_outputs: rdy=%b rv=%b mis=%b wr=%b rdata=%h addr=%h wdata=%h, want 1 0 0 0 0 0 0",
               req_ready, resp_valid, resp_misaligned, mem_write, resp_rdata, mem_address, mem_write_data);
    end
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    n_run++;
    if (req_ready !== 1'b1 || resp_valid !== 1'b0) begin
      n_fail++; $display("FAIL reset_release: rdy=%b rv=%b, want 1 0", req_ready, resp_valid);
    end
  endtask

  task automatic test_word_load();
    issue(0, 2, 0, 12, 32'h0);
    n_run++; if (r_tmo) begin n_fail++; $display("FAIL word_load_timeout: no response"); end
    n_run++; if (r_rdata !== 32'd3) begin n_fail++; $display("FAIL word_load_data: got %h want %h", r_rdata, 32'd3); end
    n_run++; if (r_lat != 2) begin n_fail++; $display("FAIL word_load_latency: got %0d want 2", r_lat); end
    n_run++; if (r_nwr != 0) begin n_fail++; $display("FAIL word_load_nowrite: got %0d writes want 0", r_nwr); end
    n_run++; if (r_rdy_bad) begin n_fail++; $display("FAIL word_load_ready: ready high while busy, want low"); end
  endtask

  task automatic test_word_store_load();
    issue(1, 2, 0, 20, 32'hDEADBEEF);
    ref_mem[5] = ref_store(ref_mem[5], 20, 2, 32'hDEADBEEF);
    n_run++; if (r_nwr != 1) begin n_fail++; $display("FAIL store_word_wcount: got %0d want 1", r_nwr); end
    n_run++; if (r_waddr !== 32'd20) begin n_fail++; $display("FAIL store_word_addr: got %h want %h", r_waddr, 32'd20); end
    n_run++; if (r_lat != 2) begin n_fail++; $display("FAIL store_word_latency: got %0d want 2", r_lat); end
    n_run++; if (r_rdata !== 32'd0 || r_mis !== 1'b0) begin n_fail++; $display("FAIL store_word_resp: rdata=%h mis=%b want 0 0", r_rdata, r_mis); end
    n_run++; if (mem[5] !== 32'hDEADBEEF) begin n_fail++; $display("FAIL store_word_mem: got %h want deadbeef", mem[5]); end
    issue(0, 2, 0, 20, 32'h0);
    n_run++; if (r_rdata !== 32'hDEADBEEF) begin n_fail++; $display("FAIL load_after_store: got %h want deadbeef", r_rdata); end
  endtask

  task automatic test_byte_store_ext();
    issue(1, 2, 0, 20, 32'h5);
    ref_mem[5] = 32'h5;
    issue(1, 0, 0, 21, 32'h123456AA);
    ref_mem[5] = ref_store(ref_mem[5], 21, 0, 32'h123456AA);
    n_run++; if (mem[5] !== 32'h0000AA05) begin n_fail++; $display("FAIL byte_store_mem: got %h want 0000aa05", mem[5]); end
    n_run++; if (r_lat != 3) begin n_fail++; $display("FAIL byte_store_latency: got %0d want 3", r_lat); end
    n_run++; if (r_nwr != 1 || r_waddr !== 32'd20) begin n_fail++; $display("FAIL byte_store_write: n=%0d addr=%h want 1 14", r_nwr, r_waddr); end
    issue(0, 0, 0, 21, 32'h0);
    n_run++; if (r_rdata !== 32'hFFFFFFAA) begin n_fail++; $display("FAIL lb_signed: got %h want ffffffaa", r_rdata); end
    issue(0, 0, 1, 21, 32'h0);
    n_run++; if (r_rdata !== 32'h000000AA) begin n_fail++; $display("FAIL lb_unsigned: got %h want 000000aa", r_rdata); end
    issue(0, 1, 0, 20, 32'h0);
    n_run++; if (r_rdata !== 32'hFFFFAA05) begin n_fail++; $display("FAIL lh_signed: got %h want ffffaa05", r_rdata); end
  endtask

  task automatic test_misaligned();
    int szs [3];
    int adrs[3];
    szs[0] = 1; adrs[0] = 13;
    szs[1] = 2; adrs[1] = 14;
    szs[2] = 3; adrs[2] = 8;
    for (int k = 0; k < 3; k++) begin
      issue(1, szs[k], 0, adrs[k], 32'h12345678);
      n_run++;
      if (r_tmo || r_mis !== 1'b1 || r_rdata !== 32'd0 || r_lat != 1 || r_nwr != 0) begin
        n_fail++;
        $display("FAIL misaligned_%0d: tmo=%0d mis=%b rdata=%h lat=%0d nwr=%0d, want 0 1 0 1 0",
                 k, r_tmo, r_mis, r_rdata, r_lat, r_nwr);
      end
      n_run++;
      if (mem[adrs[k] / 4] !== ref_mem[adrs[k] / 4]) begin
        n_fail++; $display("FAIL misaligned_mem_%0d: got %h want %h", k, mem[adrs[k] / 4], ref_mem[adrs[k] / 4]);
      end
    end
  endtask

  task automatic check_reset_outputs(input int tag);
    n_run++;
    if ({req_ready, resp_valid, resp_misaligned, mem_write} !== 4'b1000 ||
        resp_rdata !== 32'd0 || mem_address !== 32'd0 || mem_write_data !== 32'd0) begin
      n_fail++;
      $display("FAIL midop_reset_outputs_%0d: rdy=%b rv=%b mis=%b wr=%b addr=%h wdata=%h, want 1 0 0 0 0 0",
               tag, req_ready, resp_valid, resp_misaligned, mem_write, mem_address, mem_write_data);
    end
  endtask

  task automatic test_reset_mid_op();
    bit seen;
    // Abort in RMW_RD.
    @(negedge clk);
    req_write = 1; req_size = 2'b00; req_unsigned = 0; req_addr = 32'd22; req_wdata = 32'h55;
    req_valid = 1'b1;
    @(posedge clk); #1 req_valid = 1'b0;
    n_run++; if (mem_address !== 32'd20 || mem_write !== 1'b0) begin
      n_fail++; $display("FAIL midop_rmw_rd_state: addr=%h wr=%b want 14 0", mem_address, mem_write);
    end
    #1 rst_n = 1'b0;
    #1 check_reset_outputs(0);
    #1 rst_n = 1'b1;
    // Abort in RMW_WR, before the committing edge.
    @(negedge clk);
    req_valid = 1'b1;
    @(posedge clk); #1 req_valid = 1'b0;
    @(posedge clk); #1;
    n_run++; if (mem_write !== 1'b1) begin n_fail++; $display("FAIL midop_rmw_wr_state: wr=%b want 1", mem_write); end
    #1 rst_n = 1'b0;
    #1 check_reset_outputs(1);
    #1 rst_n = 1'b1;
    seen = 0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      if (resp_valid || mem_write) seen = 1;
    end
    n_run++; if (seen) begin n_fail++; $display("FAIL midop_no_resp: activity seen after abort, want none"); end
    n_run++; if (mem[5] !== ref_mem[5]) begin n_fail++; $display("FAIL midop_mem: got %h want %h", mem[5], ref_mem[5]); end
    issue(0, 2, 0, 12, 32'h0);
    n_run++; if (r_rdata !== 32'd3 || r_tmo) begin n_fail++; $display("FAIL midop_reload: got %h tmo=%0d want 3", r_rdata, r_tmo); end
  endtask

  task automatic test_back_to_back();
    bit          ws  [3];
    int          as  [3];
    logic [31:0] ds  [3];
    logic [31:0] got [3];
    logic [31:0] exp_r[3];
    int          acc [3];
    int idx, nresp, cyc, nwr;
    bit busy, rdy, rdy_bad;
    ws[0] = 0; as[0] = 12; ds[0] = 32'h0;
    ws[1] = 1; as[1] = 24; ds[1] = 32'hCAFEF00D;
    ws[2] = 0; as[2] = 24; ds[2] = 32'h0;
    exp_r[0] = ref_mem[3];
    exp_r[1] = 32'd0;
    ref_mem[6] = ref_store(ref_mem[6], 24, 2, 32'hCAFEF00D);
    exp_r[2] = ref_mem[6];
    idx = 0; nresp = 0; cyc = 0; nwr = 0; busy = 0; rdy_bad = 0;
    @(negedge clk);
    req_write = ws[0]; req_size = 2'b10; req_unsigned = 0; req_addr = as[0]; req_wdata = ds[0];
    req_valid = 1'b1;
    while (nresp < 3 && cyc < 60) begin
      if (cyc > 0) @(negedge clk);
      cyc++;
      if (req_ready && busy) rdy_bad = 1;
      if (mem_write) nwr++;
      if (resp_valid) begin got[nresp] = resp_rdata; nresp++; busy = 0; end
      rdy = req_ready;
      @(posedge clk); #1;
      if (rdy && idx < 3) begin
        acc[idx] = cyc; idx++; busy = 1;
        if (idx < 3) begin req_write = ws[idx]; req_addr = as[idx]; req_wdata = ds[idx]; end
        else req_valid = 1'b0;
      end
    end
    req_valid = 1'b0;
    n_run++; if (nresp != 3 || idx != 3) begin n_fail++; $display("FAIL b2b_count: resp=%0d acc=%0d want 3 3", nresp, idx); end
    for (int k = 0; k < 3; k++) begin
      n_run++;
      if (k < nresp && got[k] !== exp_r[k]) begin n_fail++; $display("FAIL b2b_data_%0d: got %h want %h", k, got[k], exp_r[k]); end
    end
    n_run++; if (idx == 3 && (acc[1] - acc[0] != 3 || acc[2] - acc[1] != 3)) begin
      n_fail++; $display("FAIL b2b_spacing: got %0d %0d want 3 3", acc[1] - acc[0], acc[2] - acc[1]);
    end
    n_run++; if (rdy_bad) begin n_fail++; $display("FAIL b2b_ready: ready high while busy, want low"); end
    n_run++; if (nwr != 1) begin n_fail++; $display("FAIL b2b_writes: got %0d want 1", nwr); end
    n_run++; if (mem[6] !== 32'hCAFEF00D) begin n_fail++; $display("FAIL b2b_mem: got %h want cafef00d", mem[6]); end
  endtask

  task automatic test_random();
    bit w, u, mis;
    int sz, a, wi;
    logic [31:0] d, exp_rd;
    for (int n = 0; n < 60; n++) begin
      w  = 1'($urandom_range(0, 1));
      u  = 1'($urandom_range(0, 1));
      sz = $urandom_range(0, 3);
      a  = $urandom_range(0, 255);
      d  = $urandom;
      wi = a / 4;
      mis = ref_mis(sz, a);
      exp_rd = (mis || w) ? 32'd0 : ref_load(ref_mem[wi], a, sz, u);
      issue(w, sz, u, a, d);
      if (w && !mis) ref_mem[wi] = ref_store(ref_mem[wi], a, sz, d);
      n_run++;
      if (r_tmo || r_mis !== mis || r_rdata !== exp_rd || r_lat != ref_lat(w, sz, a) || r_rdy_bad) begin
        n_fail++;
        $display("FAIL rand_%0d w=%0d sz=%0d a=%0d: tmo=%0d mis=%b rdata=%h lat=%0d rdybad=%0d, want 0 %b %h %0d 0",
                 n, w, sz, a, r_tmo, r_mis, r_rdata, r_lat, r_rdy_bad, mis, exp_rd, ref_lat(w, sz, a));
      end
      n_run++;
      if (r_nwr != ((w && !mis) ? 1 : 0) || (r_nwr == 1 && (r_waddr !== 32'(wi * 4) || r_wdata !== ref_mem[wi]))) begin
        n_fail++;
        $display("FAIL rand_write_%0d: n=%0d addr=%h data=%h, want %0d %h %h",
                 n, r_nwr, r_waddr, r_wdata, (w && !mis) ? 1 : 0, wi * 4, ref_mem[wi]);
      end
      n_run++;
      if (mem[wi] !== ref_mem[wi]) begin n_fail++; $display("FAIL rand_mem_%0d: got %h want %h", n, mem[wi], ref_mem[wi]); end
    end
  endtask

  initial begin
    for (int i = 0; i < 64; i++) begin mem[i] = 32'(i); ref_mem[i] = 32'(i); end
    test_reset();
    test_word_load();
    test_word_store_load();
    test_byte_store_ext();
    test_misaligned();
    test_reset_mid_op();
    test_back_to_back();
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

endmodule
